// File: rtl/logic_latch_pipe.sv
// Registered WIDTH-bit two-operand logic unit with a DEPTH-stage valid-tagged pipeline, stall and saturating result counter.
// Optional feature: define LOGIC_LATCH_PIPE_PARITY_EN to add parity_out, registered alongside out.
module logic_latch_pipe #(
    parameter int WIDTH   = 1,
    parameter int DEPTH   = 1,
    parameter int COUNT_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    input  logic [1:0]         op,
    input  logic               valid_in,
    input  logic               hold,
    output logic [WIDTH-1:0]   out,
    output logic               valid_out,
    output logic [COUNT_W-1:0] result_count
`ifdef LOGIC_LATCH_PIPE_PARITY_EN
    ,
    output logic               parity_out
`endif
);

    localparam logic [1:0]         OP_AND    = 2'd0;
    localparam logic [1:0]         OP_OR     = 2'd1;
    localparam logic [1:0]         OP_XOR    = 2'd2;
    localparam logic [1:0]         OP_NAND   = 2'd3;
    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [1:0]       sel,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (sel)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    logic [DEPTH-1:0][WIDTH-1:0] data_d;
    logic [DEPTH-1:0][WIDTH-1:0] data_q;
    logic [DEPTH-1:0]            valid_d;
    logic [DEPTH-1:0]            valid_q;
    logic [COUNT_W-1:0]          count_d;
    logic [COUNT_W-1:0]          count_q;

    // Next-state: hold freezes everything; otherwise stage 0 samples op/operands and the rest shift forward.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        count_d = count_q;
        if (!hold) begin
            data_d[0]  = apply_op(op, a_in, b_in);
            valid_d[0] = valid_in;
            for (int i = 1; i < DEPTH; i++) begin
                data_d[i]  = data_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
            // Count what the final stage is about to present, never wrapping.
            if (valid_d[DEPTH-1] && (count_q != COUNT_MAX)) begin
                count_d = count_q + COUNT_W'(1);
            end else begin
                count_d = count_q;
            end
        end else begin
            data_d  = data_q;
            valid_d = valid_q;
            count_d = count_q;
        end
    end

    // Pipeline and counter registers; reset discards everything in flight at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign out          = data_q[DEPTH-1];
    assign valid_out    = valid_q[DEPTH-1];
    assign result_count = count_q;

`ifdef LOGIC_LATCH_PIPE_PARITY_EN
    logic parity_d;
    logic parity_q;

    // Parity follows the final-stage data load so it stays aligned with out.
    always_comb begin
        parity_d = parity_q;
        if (!hold) begin
            parity_d = even_parity(data_d[DEPTH-1]);
        end else begin
            parity_d = parity_q;
        end
    end

    // Parity register, reset and frozen exactly like the final data stage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity_out = parity_q;
`endif

endmodule

// File: tb/tb_logic_latch_pipe.sv
// Randomized self-checking bench for logic_latch_pipe against a queue-based reference model.
module tb_logic_latch_pipe;

    localparam int W  = 8;
    localparam int D  = 3;
    localparam int CW = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  a_in = '0, b_in = '0;
    logic [1:0]    op = 2'd0;
    logic          valid_in = 1'b0, hold = 1'b0;
    logic [W-1:0]  out;
    logic          valid_out;
    logic [CW-1:0] result_count;

    logic          l_a = 1'b0, l_b = 1'b0, l_valid = 1'b0;
    logic          l_out, l_valid_out;
    logic [7:0]    l_cnt;

`ifdef LOGIC_LATCH_PIPE_PARITY_EN
    logic          parity_out;
    logic          l_par;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [W-1:0] d;
        logic         v;
    } ent_t;

    ent_t mq[$];
    int   exp_cnt = 0;

    logic [W-1:0] sweep_exp [4];

    always #5 clock = ~clock;

    logic_latch_pipe #(.WIDTH(W), .DEPTH(D), .COUNT_W(CW)) dut (
        .clock(clock), .reset(reset), .a_in(a_in), .b_in(b_in), .op(op),
        .valid_in(valid_in), .hold(hold), .out(out), .valid_out(valid_out),
        .result_count(result_count)
`ifdef LOGIC_LATCH_PIPE_PARITY_EN
        , .parity_out(parity_out)
`endif
    );

    logic_latch_pipe #(.WIDTH(1), .DEPTH(1), .COUNT_W(8)) dut_leg (
        .clock(clock), .reset(reset), .a_in(l_a), .b_in(l_b), .op(2'd0),
        .valid_in(l_valid), .hold(1'b0), .out(l_out), .valid_out(l_valid_out),
        .result_count(l_cnt)
`ifdef LOGIC_LATCH_PIPE_PARITY_EN
        , .parity_out(l_par)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        case (o)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    // The output shows the sample accepted D non-held edges ago; before that, the reset value.
    function automatic logic exp_valid();
        return (mq.size() == D) ? mq[0].v : 1'b0;
    endfunction

    function automatic logic [W-1:0] exp_out();
        return (mq.size() == D) ? mq[0].d : '0;
    endfunction

    task automatic model_edge();
        ent_t e;
        if (reset) begin
            mq.delete();
            exp_cnt = 0;
        end else if (!hold) begin
            e.d = ref_op(op, a_in, b_in);
            e.v = valid_in;
            mq.push_back(e);
            if (mq.size() > D) void'(mq.pop_front());
            if (mq.size() == D && mq[0].v && exp_cnt < CMAX) exp_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check("valid_out", 32'(valid_out), 32'(exp_valid()));
        check("result_count", 32'(result_count), 32'(exp_cnt));
        check("out", 32'(out), 32'(exp_out()));
`ifdef LOGIC_LATCH_PIPE_PARITY_EN
        check("parity_out", 32'(parity_out), 32'(^exp_out()));
`endif
    endtask

    initial begin
        int seen;
        logic found;
        sweep_exp[0] = 8'hC0;
        sweep_exp[1] = 8'hFC;
        sweep_exp[2] = 8'h3C;
        sweep_exp[3] = 8'h3F;

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            a_in = 8'($urandom); b_in = 8'($urandom); op = 2'($urandom);
            valid_in = 1'b1; hold = 1'($urandom);
            tick();
            check("rst_out", 32'(out), 32'h0);
            check("rst_valid", 32'(valid_out), 32'h0);
            check("rst_cnt", 32'(result_count), 32'h0);
        end
        reset = 1'b0; hold = 1'b0; valid_in = 1'b0;

        // Op sweep
        a_in = 8'hF0; b_in = 8'hCC;
        for (int e = 1; e <= 7; e++) begin
            if (e <= 4) begin
                op = 2'(e - 1); valid_in = 1'b1;
            end else begin
                valid_in = 1'b0;
            end
            tick();
            if (e >= 3 && e <= 6) begin
                check("sweep_valid", 32'(valid_out), 32'h1);
                check("sweep_out", 32'(out), 32'(sweep_exp[e-3]));
            end
        end
        check("sweep_cnt", 32'(result_count), 32'd4);

        // Stall mid-flight
        a_in = 8'hAA; b_in = 8'hFF; op = 2'd0; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_in = 8'($urandom); b_in = 8'($urandom); op = 2'($urandom); valid_in = 1'b1;
            tick();
            check("hold_valid", 32'(valid_out), 32'h0);
            check("hold_cnt", 32'(result_count), 32'd4);
        end
        hold = 1'b0; valid_in = 1'b0;
        found = 1'b0;
        for (int t = 8; t < 30 && !found; t++) begin
            tick();
            if (valid_out) begin
                found = 1'b1;
                check("stall_latency", 32'(t), 32'd8);
                check("stall_out", 32'(out), 32'hAA);
            end
        end
        if (!found) check("stall_timeout", 32'h0, 32'h1);

        // Reset mid-flight
        reset = 1'b1;
        tick();
        reset = 1'b0;
        valid_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a_in = 8'($urandom); b_in = 8'($urandom); op = 2'($urandom);
            tick();
        end
        valid_in = 1'b0;
        #2;
        reset = 1'b1;
        mq.delete();
        exp_cnt = 0;
        #1;
        check("mid_rst_valid", 32'(valid_out), 32'h0);
        check("mid_rst_out", 32'(out), 32'h0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mid_valid", 32'(valid_out), 32'h0);
            check("mid_cnt", 32'(result_count), 32'h0);
        end

        // Saturation
        seen = 0;
        for (int i = 0; i < 10 + D; i++) begin
            valid_in = (i < 10);
            a_in = 8'($urandom); b_in = 8'($urandom); op = 2'($urandom);
            tick();
            if (valid_out) seen++;
            check("sat_cnt", 32'(result_count), 32'((seen > CMAX) ? CMAX : seen));
        end
        check("sat_seen", 32'(seen), 32'd10);
        check("sat_final", 32'(result_count), 32'd7);

        // Random traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            a_in = 8'($urandom); b_in = 8'($urandom); op = 2'($urandom);
            valid_in = ($urandom_range(0, 3) != 0);
            hold = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 14) == 0);
            tick();
        end
        reset = 1'b0; hold = 1'b0; valid_in = 1'b0;

        // Legacy single-bit AND latch
        for (int k = 0; k < 16; k++) begin
            l_a = 1'($urandom_range(0, 1)); l_b = 1'($urandom_range(0, 1)); l_valid = 1'b1;
            tick();
            check("leg_out", 32'(l_out), 32'(l_a & l_b));
            check("leg_valid", 32'(l_valid_out), 32'h1);
            check("leg_cnt", 32'(l_cnt), 32'(k + 1));
`ifdef LOGIC_LATCH_PIPE_PARITY_EN
            check("leg_parity", 32'(l_par), 32'(l_a & l_b));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_latch_pipe.md
Name: logic_latch_pipe

Overview:
- Parametrised successor to the single-bit registered AND latch: WIDTH-bit bitwise two-operand logic unit with run-time operation select.
- Result passes through a DEPTH-stage registered pipeline with valid tagging, stall (hold) control and a saturating result counter.
- Used wherever the design needs a registered, latency-known logic operation on buses. The generated-vs-source equivalence benches drive it alongside a behavioural model.

Parameters:
- WIDTH, 1, operand/result bit width (>=1)
- DEPTH, 1, pipeline register stages from input to out (>=1)
- COUNT_W, 8, width of the saturating result counter (>=1)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- a_in  input  WIDTH  operand A
- b_in  input  WIDTH  operand B
- op  input  2  operation: 0=AND, 1=OR, 2=XOR, 3=NAND
- valid_in  input  1  a_in/b_in/op qualify this cycle
- hold  input  1  stall: freeze all pipeline state
- out  output  WIDTH  result of final stage
- valid_out  output  1  out holds a valid result
- result_count  output  COUNT_W  number of valid results emitted, saturating

Behaviour:
- Reset (async assert, sync-released by the environment):
  - out = 0, valid_out = 0, result_count = 0.
  - Every internal stage data and valid bit = 0.
- Stage 0 computes f(op, a_in, b_in) bitwise, combinationally, and registers it on the clock edge. Stages 1..DEPTH-1 shift the result forward. out/valid_out come from stage DEPTH-1.
- Latency: DEPTH clock edges from valid_in sample to valid_out. DEPTH=1 gives one-cycle behaviour, identical to the legacy and_latch when op=0 and WIDTH=1.
- op is sampled with the data. A change of op never affects results already in flight.
- valid_in=0 with hold=0: a bubble enters stage 0 (valid=0). Data registers still load the computed value; out is don't-care-free but must be ignored while valid_out=0.
- hold=1: no register changes, including result_count. Inputs presented that cycle are dropped. hold overrides valid_in.
- result_count increments by 1 on each edge where hold=0 and stage DEPTH-1 loads valid=1. It saturates at 2^COUNT_W-1 and never wraps.
- Simultaneous hold=1 and reset: reset wins.
- Reset asserted mid-pipeline: all in-flight results are discarded immediately (async). No valid_out appears for pre-reset inputs after release.
- Back-to-back valid_in each cycle gives one result per cycle (full throughput).
- X on inputs with valid_in=0 must not propagate into valid_out or result_count.

Optional Feature:
- Macro: LOGIC_LATCH_PIPE_PARITY_EN.
- Defined: extra output parity_out (1 bit) carries even parity (XOR reduction) of out. It is registered alongside out in the final stage, so it is aligned with out on every cycle. It resets to 0 and is frozen by hold.
- Undefined: no parity_out port and no parity logic. All other behaviour is unchanged.

Test Plan:
- Reset check: WIDTH=8, DEPTH=3; assert reset for 2 cycles with random inputs -> out=0x00, valid_out=0, result_count=0 throughout.
- Op sweep: a_in=0xF0, b_in=0xCC, op=0,1,2,3 on consecutive cycles, valid_in=1 -> after 3 edges out = 0xC0, 0xFC, 0x3C, 0x3F on consecutive cycles, valid_out=1 each, result_count=4.
- Stall: feed 0xAA AND 0xFF, then hold=1 for 5 cycles mid-flight -> out/valid_out/result_count unchanged during hold. 0xAA emerges exactly 5 cycles later than without stall.
- Reset mid-flight: 2 valid inputs in pipeline (DEPTH=3), pulse reset for 1 cycle -> valid_out never asserts for them, result_count stays 0.
- Saturation: COUNT_W=3, stream 10 valid results -> result_count reads 7 after the 7th and stays 7.
- Legacy equivalence: WIDTH=1, DEPTH=1, op=0, 16 random a/b pairs -> out equals a&b one edge after sampling, matching the behavioural model each cycle. With LOGIC_LATCH_PIPE_PARITY_EN defined, parity_out equals out.
